// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: turns the UART receiver byte stream into register-write
// commands. A frame is HEADER, addr, data and, when UART_CMD_CHKSUM_EN is
// defined, a checksum byte equal to (addr + data) mod 256.
//
// Optional feature macro: UART_CMD_CHKSUM_EN (adds the CHK state and compare).
//
// Ports:
//   Clk        system clock
//   Reset      synchronous, active-high reset
//   Rx_Data    received byte, valid while Rx_Done=1
//   Rx_Done    one-cycle byte-valid pulse from the receiver
//   Wr_En      one-cycle register-write strobe
//   Wr_Addr    write address, held until the next write
//   Wr_Data    write data, held until the next write
//   Frame_Err  one-cycle pulse on checksum mismatch or inter-byte timeout
//   Busy       frame in progress (state != IDLE), combinational
//   Frame_Cnt  completed writes, wraps
//   Err_Cnt    Frame_Err pulses, saturates at 255
module uart_rx_cmd_ctrl #(
    parameter logic [7:0]  HEADER      = 8'h55,
    parameter int unsigned TIMEOUT_CYC = 17360,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [7:0]       Rx_Data,
    input  logic             Rx_Done,
    output logic             Wr_En,
    output logic [7:0]       Wr_Addr,
    output logic [7:0]       Wr_Data,
    output logic             Frame_Err,
    output logic             Busy,
    output logic [CNT_W-1:0] Frame_Cnt,
    output logic [7:0]       Err_Cnt
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
`ifdef UART_CMD_CHKSUM_EN
    localparam logic [1:0] CHK  = 2'd3;
`endif

    logic [1:0]       state, state_nxt;
    logic [7:0]       addr_r, addr_nxt;
    logic [7:0]       data_r, data_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             commit_c;
    logic             err_c;
    logic             tmo_c;

    assign Busy = (state != IDLE);

    // A byte arriving on the terminal-count cycle wins over the timeout.
    assign tmo_c = (state != IDLE) && !Rx_Done && (tmr == TMR_W'(TIMEOUT_CYC - 1));

    // Next-state, byte capture and commit/error decisions.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_r;
        data_nxt  = data_r;
        commit_c  = 1'b0;
        err_c     = 1'b0;
        tmr_nxt   = tmr + TMR_W'(1);

        case (state)
            IDLE: begin
                if (Rx_Done && (Rx_Data == HEADER)) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (Rx_Done) begin
                    addr_nxt  = Rx_Data;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (Rx_Done) begin
                    data_nxt  = Rx_Data;
`ifdef UART_CMD_CHKSUM_EN
                    state_nxt = CHK;
`else
                    commit_c  = 1'b1;
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef UART_CMD_CHKSUM_EN
            CHK: begin
                if (Rx_Done) begin
                    if (Rx_Data == 8'(addr_r + data_r)) begin
                        commit_c = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase

        if (tmo_c) begin
            err_c     = 1'b1;
            state_nxt = IDLE;
        end

        if (Rx_Done || (state == IDLE) || tmo_c) begin
            tmr_nxt = '0;
        end
    end

    // State, timer, registered outputs and counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            addr_r    <= '0;
            data_r    <= '0;
            tmr       <= '0;
            Wr_En     <= 1'b0;
            Wr_Addr   <= '0;
            Wr_Data   <= '0;
            Frame_Err <= 1'b0;
            Frame_Cnt <= '0;
            Err_Cnt   <= '0;
        end else begin
            state     <= state_nxt;
            addr_r    <= addr_nxt;
            data_r    <= data_nxt;
            tmr       <= tmr_nxt;
            Wr_En     <= commit_c;
            Frame_Err <= err_c;
            if (commit_c) begin
                Wr_Addr   <= addr_nxt;
                Wr_Data   <= data_nxt;
                Frame_Cnt <= Frame_Cnt + CNT_W'(1);
            end
            if (err_c && (Err_Cnt != 8'hFF)) begin
                Err_Cnt <= Err_Cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/uart_rx_cmd_ctrl.md
Name: uart_rx_cmd_ctrl

Overview:
Frame controller that sits directly behind the UART byte receiver and sequences its byte stream into register-write commands.
- Hunts for a header byte, then collects address, data and (optionally) a checksum byte.
- Issues a one-cycle write strobe to the downstream register bank and aborts stalled frames on an inter-byte timeout.
- Keeps frame and error counters for debug LEDs and readback.

Parameters:
HEADER, 8'h55, start-of-frame byte
TIMEOUT_CYC, 17360, max Clk cycles between bytes inside a frame (4 byte times at 50 MHz / 115200)
CNT_W, 16, width of Frame_Cnt

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Rx_Data  in  8  received byte, valid when Rx_Done=1
Rx_Done  in  1  one-cycle byte-valid pulse from receiver
Wr_En  out  1  one-cycle register-write strobe
Wr_Addr  out  8  write address, stable while Wr_En=1 and until next write
Wr_Data  out  8  write data, stable while Wr_En=1 and until next write
Frame_Err  out  1  one-cycle pulse on checksum mismatch or timeout
Busy  out  1  high while a frame is in progress (state != IDLE)
Frame_Cnt  out  CNT_W  count of completed writes, wraps
Err_Cnt  out  8  count of Frame_Err pulses, saturates at 255

Behaviour:
- One clock domain (Clk); Reset is synchronous, active-high, sampled on posedge Clk.
- Reset values:
  - state=IDLE
  - Wr_En=0, Frame_Err=0, Busy=0
  - Wr_Addr=0, Wr_Data=0
  - Frame_Cnt=0, Err_Cnt=0
  - timeout counter=0
- Reset mid-frame: partial frame discarded; no Wr_En, no Frame_Err, Err_Cnt cleared.
- Byte acceptance: every cycle with Rx_Done=1 consumes one byte. Upstream guarantees single-cycle pulses.
- FSM states: IDLE, ADDR, DATA, CHK (CHK exists only with the optional feature).
  - IDLE: on Rx_Done with Rx_Data==HEADER go to ADDR. Any other byte is silently dropped (no error).
  - ADDR: on Rx_Done latch addr_r=Rx_Data, go to DATA.
  - DATA: on Rx_Done latch data_r=Rx_Data.
    - Without checksum: commit, go to IDLE.
    - With checksum: go to CHK.
  - CHK: on Rx_Done compare Rx_Data with (addr_r+data_r) mod 256.
    - Equal: commit.
    - Not equal: error.
    - Either case: go to IDLE.
- Commit: registered. Wr_En=1 exactly one cycle, on the cycle after the Rx_Done carrying the final byte; Wr_Addr/Wr_Data update in that same cycle; Frame_Cnt+1 (wraps at 2^CNT_W).
- Error: Frame_Err=1 one cycle after the detecting edge; Err_Cnt+1 unless already 255; no Wr_En; Wr_Addr/Wr_Data hold their previous values.
- Timeout:
  - Counter clears on every Rx_Done and whenever in IDLE; otherwise increments in ADDR/DATA/CHK.
  - When counter==TIMEOUT_CYC-1 with no Rx_Done that cycle: error, go to IDLE.
  - Rx_Done in the same cycle as terminal count: byte wins, no timeout.
- Back-to-back frames: FSM is in IDLE during the Wr_En/Frame_Err cycle, so a HEADER arriving in that cycle is accepted.
- A HEADER byte received in ADDR/DATA/CHK is ordinary payload, not a resync.
- Busy is combinational from state (state != IDLE).

Optional Feature:
UART_CMD_CHKSUM_EN
- Defined: frame is HEADER, addr, data, chk; CHK state present; mismatch raises Frame_Err.
- Undefined: frame is HEADER, addr, data; CHK state and compare logic removed; Frame_Err arises only from timeout.

Test Plan:
- Reset then bytes 55,10,A5 (no CHKSUM_EN), 1 Clk pulses -> Wr_En one cycle after 3rd Rx_Done; Wr_Addr=10, Wr_Data=A5; Frame_Cnt=1; Frame_Err never high.
- CHKSUM_EN: bytes 55,20,F0,10 -> write 20/F0, Frame_Cnt=1. Then bytes 55,20,F0,11 -> Frame_Err pulse, Err_Cnt=1, no Wr_En, Wr_Addr/Wr_Data still 20/F0.
- Garbage 00,AA,FF then 55,01,02(,03) -> garbage ignored, one write 01/02, Err_Cnt=0.
- Bytes 55,30 then silence -> Frame_Err exactly TIMEOUT_CYC cycles after 30's Rx_Done, Busy drops, Err_Cnt=1. Repeat with a third byte arriving on the terminal-count cycle -> no timeout, frame continues.
- Reset asserted for 1 cycle between addr and data bytes -> Busy=0, all counters 0. Following full frame 55,40,41(,81) -> single write 40/41.
- 256 consecutive bad-checksum frames -> Err_Cnt saturates at 255. Frames sent back-to-back with HEADER on the Wr_En cycle -> every frame accepted, Frame_Cnt increments each time.
